// File: rtl/serial_unlock_pkg.sv
// serial_unlock_pkg: receiver state encoding, default line rates and baud divider helper.
package serial_unlock_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} rx_state_t;
  localparam int DEF_CLK_HZ = 12000000;
  localparam int DEF_BAUD = 115200;
  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction
endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 receiver with input synchronizer; strobes a byte on a good stop bit
// and flags frame_err when the stop bit is low.
module uart_rx_core
  import serial_unlock_pkg::*;
#(
  parameter int CLK_HZ = DEF_CLK_HZ,
  parameter int BAUD = DEF_BAUD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);
  localparam int DIV = baud_div(CLK_HZ, BAUD);
  localparam int CW = $clog2(DIV + 1);
  rx_state_t r_state, w_next;
  logic [1:0] r_sync;
  logic [CW-1:0] r_cnt;
  logic [2:0] r_bit;
  logic [7:0] r_shift, r_data;
  logic r_valid, r_ferr;
  logic w_rx, w_tick, w_shift, w_stop_ok, w_stop_bad;
  assign w_rx = r_sync[1];
  always_ff @(posedge clk)
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (!w_rx) w_next = START;
      START:     if (w_tick) w_next = w_rx ? IDLE : DATA;
      DATA:      if (w_tick && r_bit == 3'd7) w_next = STOP;
      STOP:      if (w_tick) w_next = w_rx ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (w_rx) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end
  // START ticks at mid-bit; every later tick is one full bit period after the previous one
  always_comb begin
    w_tick = (r_state == START) ? (r_cnt == CW'(DIV / 2)) : (r_cnt == CW'(DIV - 1));
    w_shift = (r_state == DATA) && w_tick;
    w_stop_ok = (r_state == STOP) && w_tick && w_rx;
    w_stop_bad = (r_state == STOP) && w_tick && !w_rx;
  end
  always_ff @(posedge clk)
    if (!reset) begin
      r_sync <= 2'b11;
      r_cnt <= '0;
      r_bit <= '0;
      r_shift <= '0;
      r_data <= '0;
      r_valid <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], rx};
      r_cnt <= (r_state == IDLE || r_state == WAIT_IDLE || w_tick) ? '0 : r_cnt + 1'b1;
      if (w_shift) begin
        r_shift <= {w_rx, r_shift[7:1]};
        r_bit <= r_bit + 1'b1;
      end
      if (w_stop_ok) r_data <= r_shift;
      r_valid <= w_stop_ok;
      r_ferr <= w_stop_bad;
    end
  assign byte_valid = r_valid;
  assign byte_data = r_data;
  assign frame_err = r_ferr;
endmodule

// File: rtl/serial_unlock.sv
// serial_unlock: UART password lock; green LED latches on a full correct password, red LED flags a bad attempt.
// SERIAL_UNLOCK_FRAME_ERR_EN: a framing error while locked restarts the attempt and lights the red LED.
module serial_unlock
  import serial_unlock_pkg::*;
#(
  parameter int CLK_HZ = DEF_CLK_HZ,
  parameter int BAUD = DEF_BAUD,
  parameter int PW_LEN = 8,
  parameter logic [8*PW_LEN-1:0] PASSWORD = '0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       led_g_n,
  output logic       led_r_n,
  output logic       byte_valid,
  output logic [7:0] byte_data
);
  logic w_valid, w_ferr, w_mis, w_last;
  logic [7:0] w_data, w_pw;
  logic [3:0] r_idx;
  logic r_mis, r_unlocked, r_fail;
  uart_rx_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .byte_valid(w_valid),
    .byte_data(w_data),
    .frame_err(w_ferr)
  );
  assign w_pw = PASSWORD[8*r_idx +: 8];
  assign w_mis = r_mis | (w_data != w_pw);
  assign w_last = r_idx == 4'(PW_LEN - 1);
  always_ff @(posedge clk)
    if (!reset) begin
      r_idx <= '0;
      r_mis <= 1'b0;
      r_unlocked <= 1'b0;
      r_fail <= 1'b0;
    end else begin
      if (w_valid && !r_unlocked) begin
        r_idx <= w_last ? '0 : r_idx + 1'b1;
        r_mis <= !w_last && w_mis;
        if (w_last && !w_mis) r_unlocked <= 1'b1;
      end
      // any received byte clears a previous failure indication
      if (w_valid) r_fail <= !r_unlocked && w_last && w_mis;
`ifdef SERIAL_UNLOCK_FRAME_ERR_EN
      if (w_ferr && !r_unlocked) begin
        r_idx <= '0;
        r_mis <= 1'b0;
        r_fail <= 1'b1;
      end
`endif
    end
`ifndef SERIAL_UNLOCK_FRAME_ERR_EN
  logic w_unused;
  assign w_unused = w_ferr;
`endif
  assign led_g_n = !r_unlocked;
  assign led_r_n = !r_fail;
  assign byte_valid = w_valid;
  assign byte_data = w_data;
endmodule

// File: tb/tb_serial_unlock.sv
// tb_serial_unlock: table-driven frames against the default-rate lock, plus reset and timing corner cases.
module tb_serial_unlock;
  localparam int DIV = 104;
  localparam logic [63:0] PW = 64'h0706050403020100;
  logic clk = 1'b0, reset = 1'b0, rx = 1'b1;
  logic led_g_n, led_r_n, byte_valid;
  logic [7:0] byte_data;
  int checks = 0, errors = 0;
  int n_valid = 0;
  longint cyc = 0, lock_valid_cyc = -10, g_fall_cyc = -20;
  logic g_prev = 1'b1;
  typedef struct {
    int kind;
    logic [7:0] data;
    int exp_n;
    logic [7:0] exp_d;
    logic exp_g;
    logic exp_r;
  } vec_t;
  vec_t vecs[$];

  serial_unlock #(.PASSWORD(PW)) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .led_g_n(led_g_n),
    .led_r_n(led_r_n),
    .byte_valid(byte_valid),
    .byte_data(byte_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    g_prev <= led_g_n;
    if (byte_valid) n_valid <= n_valid + 1;
    if (byte_valid && led_g_n) lock_valid_cyc <= cyc;
    if (g_prev && !led_g_n) g_fall_cyc <= cyc;
  end

  assert property (@(posedge clk) byte_valid |=> !byte_valid)
    else begin errors++; $display("FAIL assert byte_valid two consecutive cycles"); end
  assert property (@(posedge clk) $past(reset) |-> !$rose(led_g_n))
    else begin errors++; $display("FAIL assert led_g_n rose while out of reset"); end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    hold(1'b0, DIV);
    for (int i = 0; i < 8; i++) hold(b[i], DIV);
    hold(stop, DIV);
    if (!stop) hold(1'b1, DIV);
  endtask

  task automatic add(input int k, input logic [7:0] d, input int n, input logic [7:0] ed,
                     input logic g, input logic r);
    vec_t v;
    v.kind = k; v.data = d; v.exp_n = n; v.exp_d = ed; v.exp_g = g; v.exp_r = r;
    vecs.push_back(v);
  endtask

  task automatic reset_mid_frame();
    hold(1'b0, DIV);
    hold(1'b1, 150);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("midrst byte_valid", 32'(byte_valid), 32'd0);
    check("midrst byte_data", 32'(byte_data), 32'h00);
    check("midrst led_g_n", 32'(led_g_n), 32'd1);
    check("midrst led_r_n", 32'(led_r_n), 32'd1);
    hold(1'b1, 1200);
  endtask

  initial begin
    // kind: 0 good frame, 1 short low glitch, 2 frame with low stop bit, 3 reset mid-frame
    add(1, 8'h00, 0, 8'h00, 1, 1);
    add(0, 8'h00, 1, 8'h00, 1, 1);
    add(0, 8'h01, 1, 8'h01, 1, 1);
    add(1, 8'h00, 0, 8'h01, 1, 1);
    for (int b = 2; b < 7; b++) add(0, 8'(b), 1, 8'(b), 1, 1);
    add(0, 8'h07, 1, 8'h07, 0, 1);
    add(0, 8'hAA, 1, 8'hAA, 0, 1);
    add(3, 8'h00, 0, 8'h00, 1, 1);
    add(0, 8'h00, 1, 8'h00, 1, 1);
    add(0, 8'h01, 1, 8'h01, 1, 1);
    add(0, 8'h02, 1, 8'h02, 1, 1);
    add(0, 8'hFF, 1, 8'hFF, 1, 1);
    for (int b = 4; b < 7; b++) add(0, 8'(b), 1, 8'(b), 1, 1);
    add(0, 8'h07, 1, 8'h07, 1, 0);
    add(0, 8'h00, 1, 8'h00, 1, 1);
`ifdef SERIAL_UNLOCK_FRAME_ERR_EN
    add(2, 8'h55, 0, 8'h00, 1, 0);
    add(0, 8'h00, 1, 8'h00, 1, 1);
`else
    add(2, 8'h55, 0, 8'h00, 1, 1);
`endif
    for (int b = 1; b < 7; b++) add(0, 8'(b), 1, 8'(b), 1, 1);
    add(0, 8'h07, 1, 8'h07, 0, 1);

    repeat (3) @(negedge clk);
    check("reset byte_valid", 32'(byte_valid), 32'd0);
    check("reset byte_data", 32'(byte_data), 32'h00);
    check("reset led_g_n", 32'(led_g_n), 32'd1);
    check("reset led_r_n", 32'(led_r_n), 32'd1);
    reset = 1'b1;
    hold(1'b1, 20);

    for (int i = 0; i < vecs.size(); i++) begin
      int n0;
      n0 = n_valid;
      case (vecs[i].kind)
        0: send_frame(vecs[i].data, 1'b1);
        1: begin hold(1'b0, 30); hold(1'b1, 200); end
        2: send_frame(vecs[i].data, 1'b0);
        default: reset_mid_frame();
      endcase
      check($sformatf("v%0d strobes", i), 32'(n_valid - n0), 32'(vecs[i].exp_n));
      check($sformatf("v%0d byte_data", i), 32'(byte_data), 32'(vecs[i].exp_d));
      check($sformatf("v%0d led_g_n", i), 32'(led_g_n), 32'(vecs[i].exp_g));
      check($sformatf("v%0d led_r_n", i), 32'(led_r_n), 32'(vecs[i].exp_r));
    end

    check("unlock latency", 32'(g_fall_cyc - lock_valid_cyc), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
